quad_decoder: RTL and testbench

Front-end stage that turns a two-channel quadrature encoder (A/B) into qualified count events for the 4-bit up/down counter. Synchronises and glitch-filters both asynchronous inputs, tracks the Gray-code phase with a 4-state machine, and emits a one-cycle `step` pulse with a registered `up` direction on every valid edge (x4 decoding). `step` is the counter's count-enable and `up` drives its `isUP`. Illegal double-edge transitions are flagged instead of counted.

---
 rtl/quad_pkg.sv | 46 ++++
 rtl/quad_glitch_filter.sv | 61 ++++++
 rtl/quad_decoder.sv | 90 +++++++++
 tb/tb_quad_decoder.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder.
// Phase encoding is {A,B}; the up sequence is 00->10->11->01->00.
package quad_pkg;

  localparam int FILTER_CNT_W = 4;
  localparam int SEED_W       = 5;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S10 = 2'b10,
    S11 = 2'b11,
    S01 = 2'b01
  } quad_phase_t;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } quad_dir_t;

  // Classify a phase move: one-bit step (with direction) or a double edge.
  function automatic quad_dir_t quad_dir(
    quad_phase_t prev,
    quad_phase_t next
  );
    quad_dir_t   r;
    quad_phase_t up_nxt;
    logic [1:0]  diff;
    r    = '0;
    diff = prev ^ next;
    case (prev)
      S00:     up_nxt = S10;
      S10:     up_nxt = S11;
      S11:     up_nxt = S01;
      default: up_nxt = S00;
    endcase
    if (diff == 2'b11) begin
      r.illegal = 1'b1;
    end else if (diff != 2'b00) begin
      r.valid = 1'b1;
      r.up    = (next == up_nxt);
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: 2-flop synchroniser followed by a
// persistence filter; seed forces the filter to track s2.
module quad_glitch_filter
  import quad_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  input  logic seed,
  output logic filt,
  output logic filt_nxt
);

  localparam logic [FILTER_CNT_W-1:0] LEN =
    FILTER_CNT_W'(FILTER_LEN);

  logic                    s1_q, s1_d;
  logic                    s2_q, s2_d;
  logic                    filt_q, filt_d;
  logic [FILTER_CNT_W-1:0] cnt_q, cnt_d;
  logic [FILTER_CNT_W-1:0] cnt_inc;

  // Accept a new level only after LEN consecutive disagreeing cycles.
  always_comb begin
    s1_d    = d_in;
    s2_d    = s1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    cnt_inc = cnt_q + FILTER_CNT_W'(1);
    if (seed) begin
      filt_d = s2_q;
    end else if (s2_q != filt_q) begin
      if (cnt_inc == LEN) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt     = filt_q;
  assign filt_nxt = filt_d;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature front end: filtered A/B phase tracking with x4
// step/direction output and double-edge error flagging.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  input  logic err_clr,
  output logic step,
  output logic up,
  output logic err,
  output logic err_sticky
);

  localparam logic [SEED_W-1:0] SEED_N =
    SEED_W'(FILTER_LEN + 2);

  logic               filt_a, filt_b;
  logic               nxt_a, nxt_b;
  logic               seed;
  logic [SEED_W-1:0]  seed_q, seed_d;
  quad_phase_t        state_q, state_d;
  quad_phase_t        cur;
  quad_dir_t          dir;
  logic               step_q, step_d;
  logic               up_q, up_d;
  logic               err_q, err_d;
  logic               stk_q, stk_d;

  assign seed = (seed_q < SEED_N);

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_a (
    .clk      (clk),
    .reset    (reset),
    .d_in     (a_in),
    .seed     (seed),
    .filt     (filt_a),
    .filt_nxt (nxt_a)
  );

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_b (
    .clk      (clk),
    .reset    (reset),
    .d_in     (b_in),
    .seed     (seed),
    .filt     (filt_b),
    .filt_nxt (nxt_b)
  );

  // Decode phase moves; while seeding, state follows the loaded filters.
  always_comb begin
    cur     = quad_phase_t'({filt_a, filt_b});
    dir     = quad_dir(state_q, cur);
    seed_d  = seed ? seed_q + SEED_W'(1) : seed_q;
    state_d = seed ? quad_phase_t'({nxt_a, nxt_b}) : cur;
    step_d  = !seed && dir.valid;
    err_d   = !seed && dir.illegal;
    up_d    = step_d ? dir.up : up_q;
    stk_d   = err_d || (stk_q && !err_clr);
  end

  // Seed timer, phase register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_q  <= '0;
      state_q <= S00;
      step_q  <= 1'b0;
      up_q    <= 1'b0;
      err_q   <= 1'b0;
      stk_q   <= 1'b0;
    end else begin
      seed_q  <= seed_d;
      state_q <= state_d;
      step_q  <= step_d;
      up_q    <= up_d;
      err_q   <= err_d;
      stk_q   <= stk_d;
    end
  end

  assign step       = step_q;
  assign up         = up_q;
  assign err        = err_q;
  assign err_sticky = stk_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus a random walk,
// each cycle checked against a sliding-window reference model.
module tb_quad_decoder;

  localparam int FL = 4;

  logic clk = 1'b0;
  logic reset, a_in, b_in, err_clr;
  logic step, up, err, err_sticky;

  int ncmp = 0;
  int nbad = 0;

  quad_decoder #(.FILTER_LEN(FL)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_in       (a_in),
    .b_in       (b_in),
    .err_clr    (err_clr),
    .step       (step),
    .up         (up),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit       m_s1a, m_s2a, m_s1b, m_s2b, m_fa, m_fb;
  bit [1:0] m_st, m_cur;
  bit       m_step, m_up, m_err, m_stk;
  int       m_seed = FL + 2;
  int       m_cyc  = 0;
  int       m_d;
  bit       qa[$], qb[$];

  // position along the up sequence 00,10,11,01
  function automatic int pos(bit [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // accepted when the last FL synchronised samples all disagree
  function automatic bit settled(bit q[$], bit f);
    if (q.size() != FL) return 1'b0;
    foreach (q[i]) if (q[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    m_cyc++;
    if (reset) begin
      {m_s1a, m_s2a, m_s1b, m_s2b} = '0;
      {m_fa, m_fb} = '0;
      m_st = 2'b00;
      {m_step, m_up, m_err, m_stk} = '0;
      m_seed = FL + 2;
      qa.delete();
      qb.delete();
    end else begin
      if (m_seed > 0) begin
        m_fa   = m_s2a;
        m_fb   = m_s2b;
        m_st   = {m_fa, m_fb};
        m_step = 1'b0;
        m_err  = 1'b0;
        m_seed--;
        qa.delete();
        qb.delete();
      end else begin
        m_cur  = {m_fa, m_fb};
        m_d    = (pos(m_cur) - pos(m_st) + 4) % 4;
        m_step = (m_d == 1) || (m_d == 3);
        m_err  = (m_d == 2);
        if (m_step) m_up = (m_d == 1);
        m_st = m_cur;
        qa.push_back(m_s2a);
        qb.push_back(m_s2b);
        if (qa.size() > FL) void'(qa.pop_front());
        if (qb.size() > FL) void'(qb.pop_front());
        if (settled(qa, m_fa)) m_fa = m_s2a;
        if (settled(qb, m_fb)) m_fb = m_s2b;
      end
      m_stk = m_err || (m_stk && !err_clr);
      m_s2a = m_s1a;
      m_s1a = a_in;
      m_s2b = m_s1b;
      m_s1b = b_in;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    a_in = 1'b0;
    b_in = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    ncmp++;
    if ({step, up, err, err_sticky} !== 4'b0000) begin
      nbad++;
      $display("FAIL reset_vals got=%b exp=0000",
               {step, up, err, err_sticky});
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      ncmp++;
      if ({step, up, err, err_sticky} !==
          {m_step, m_up, m_err, m_stk}) begin
        nbad++;
        $display("FAIL idle cyc=%0d got=%b exp=%b", m_cyc,
                 {step, up, err, err_sticky},
                 {m_step, m_up, m_err, m_stk});
      end
      ncmp++;
      if ({step, up, err, err_sticky} !== 4'b0000) begin
        nbad++;
        $display("FAIL idle_zero cyc=%0d got=%b exp=0000",
                 m_cyc, {step, up, err, err_sticky});
      end
    end
  endtask

  task automatic test_up_seq();
    logic [1:0] ph [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int ns = 0;
    int k = 0;
    int lat = -1;
    for (int i = 0; i < 4; i++) begin
      {a_in, b_in} = ph[i];
      if (i == 0) k = m_cyc + 1;
      repeat (10) begin
        @(negedge clk);
        ncmp++;
        if ({step, up, err, err_sticky} !==
            {m_step, m_up, m_err, m_stk}) begin
          nbad++;
          $display("FAIL up_seq cyc=%0d got=%b exp=%b", m_cyc,
                   {step, up, err, err_sticky},
                   {m_step, m_up, m_err, m_stk});
        end
        if (step === 1'b1) begin
          ns++;
          if (lat < 0) lat = m_cyc - k;
          ncmp++;
          if (up !== 1'b1) begin
            nbad++;
            $display("FAIL up_dir got=%b exp=1", up);
          end
        end
      end
    end
    ncmp++;
    if (ns !== 4) begin
      nbad++;
      $display("FAIL up_count got=%0d exp=4", ns);
    end
    ncmp++;
    if (lat !== FL + 2) begin
      nbad++;
      $display("FAIL latency got=%0d exp=%0d", lat, FL + 2);
    end
  endtask

  task automatic test_down_rev();
    logic [1:0] ph [8] = '{2'b01, 2'b11, 2'b10, 2'b00,
                           2'b10, 2'b11, 2'b10, 2'b00};
    logic [7:0] ups = '0;
    int ns = 0;
    for (int i = 0; i < 8; i++) begin
      {a_in, b_in} = ph[i];
      repeat (10) begin
        @(negedge clk);
        ncmp++;
        if ({step, up, err, err_sticky} !==
            {m_step, m_up, m_err, m_stk}) begin
          nbad++;
          $display("FAIL down_rev cyc=%0d got=%b exp=%b", m_cyc,
                   {step, up, err, err_sticky},
                   {m_step, m_up, m_err, m_stk});
        end
        if (step === 1'b1 && ns < 8) begin
          ups[ns] = up;
          ns++;
        end
      end
    end
    ncmp++;
    if (ns !== 8 || ups !== 8'b0011_0000) begin
      nbad++;
      $display("FAIL down_rev_seq got=%0d/%b exp=8/00110000",
               ns, ups);
    end
  endtask

  task automatic test_glitch();
    int ns = 0;
    for (int w = 3; w <= 4; w++) begin
      a_in = 1'b1;
      repeat (w) begin
        @(negedge clk);
        ncmp++;
        if ({step, up, err, err_sticky} !==
            {m_step, m_up, m_err, m_stk}) begin
          nbad++;
          $display("FAIL glitch cyc=%0d got=%b exp=%b", m_cyc,
                   {step, up, err, err_sticky},
                   {m_step, m_up, m_err, m_stk});
        end
        if (step === 1'b1) ns++;
      end
      a_in = 1'b0;
      repeat (14) begin
        @(negedge clk);
        ncmp++;
        if ({step, up, err, err_sticky} !==
            {m_step, m_up, m_err, m_stk}) begin
          nbad++;
          $display("FAIL glitch cyc=%0d got=%b exp=%b", m_cyc,
                   {step, up, err, err_sticky},
                   {m_step, m_up, m_err, m_stk});
        end
        if (step === 1'b1) ns++;
      end
      ncmp++;
      if (ns !== (w == 3 ? 0 : 2)) begin
        nbad++;
        $display("FAIL glitch_w%0d steps got=%0d exp=%0d",
                 w, ns, (w == 3 ? 0 : 2));
      end
      ns = 0;
    end
  endtask

  task automatic test_err();
    int ne = 0;
    int ns = 0;
    {a_in, b_in} = 2'b11;
    repeat (10) begin
      @(negedge clk);
      ncmp++;
      if ({step, up, err, err_sticky} !==
          {m_step, m_up, m_err, m_stk}) begin
        nbad++;
        $display("FAIL err cyc=%0d got=%b exp=%b", m_cyc,
                 {step, up, err, err_sticky},
                 {m_step, m_up, m_err, m_stk});
      end
      if (err === 1'b1) ne++;
      if (step === 1'b1) ns++;
    end
    ncmp++;
    if (ne !== 1 || ns !== 0 || err_sticky !== 1'b1) begin
      nbad++;
      $display("FAIL err_first got=%0d/%0d/%b exp=1/0/1",
               ne, ns, err_sticky);
    end
    {a_in, b_in} = 2'b00;
    repeat (FL + 2) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    ncmp++;
    if ({err, err_sticky} !== 2'b11) begin
      nbad++;
      $display("FAIL err_clr_race got=%b exp=11",
               {err, err_sticky});
    end
    repeat (3) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    ncmp++;
    if ({err, err_sticky} !== 2'b00) begin
      nbad++;
      $display("FAIL err_clr_lone got=%b exp=00",
               {err, err_sticky});
    end
    ncmp++;
    if ({step, up, err, err_sticky} !==
        {m_step, m_up, m_err, m_stk}) begin
      nbad++;
      $display("FAIL err_model got=%b exp=%b",
               {step, up, err, err_sticky},
               {m_step, m_up, m_err, m_stk});
    end
  endtask

  task automatic test_reseed();
    int bad = 0;
    int ns = 0;
    {a_in, b_in} = 2'b11;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (FL + 8) begin
      @(negedge clk);
      if (step !== 1'b0 || err !== 1'b0) bad++;
      ncmp++;
      if ({step, up, err, err_sticky} !==
          {m_step, m_up, m_err, m_stk}) begin
        nbad++;
        $display("FAIL reseed cyc=%0d got=%b exp=%b", m_cyc,
                 {step, up, err, err_sticky},
                 {m_step, m_up, m_err, m_stk});
      end
    end
    ncmp++;
    if (bad !== 0) begin
      nbad++;
      $display("FAIL seed_quiet got=%0d pulses exp=0", bad);
    end
    a_in = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (step === 1'b1 && up === 1'b1 && err === 1'b0) ns++;
    end
    ncmp++;
    if (ns !== 1) begin
      nbad++;
      $display("FAIL seed_s11 up_steps got=%0d exp=1", ns);
    end
  endtask

  task automatic test_mid_reset();
    a_in = 1'b1;
    repeat (FL + 2) begin
      @(negedge clk);
      ncmp++;
      if ({step, up, err, err_sticky} !==
          {m_step, m_up, m_err, m_stk}) begin
        nbad++;
        $display("FAIL mid_rst cyc=%0d got=%b exp=%b", m_cyc,
                 {step, up, err, err_sticky},
                 {m_step, m_up, m_err, m_stk});
      end
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      ncmp++;
      if ({step, up, err, err_sticky} !== 4'b0000) begin
        nbad++;
        $display("FAIL mid_rst_zero got=%b exp=0000",
                 {step, up, err, err_sticky});
      end
    end
    reset = 1'b0;
    repeat (15) begin
      @(negedge clk);
      ncmp++;
      if ({step, up, err, err_sticky} !==
          {m_step, m_up, m_err, m_stk}) begin
        nbad++;
        $display("FAIL mid_rst_after cyc=%0d got=%b exp=%b",
                 m_cyc, {step, up, err, err_sticky},
                 {m_step, m_up, m_err, m_stk});
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] p;
    int r;
    int n;
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      p = {a_in, b_in};
      n = $urandom_range(FL + 1, FL + 8);
      if (r == 0) begin
        {a_in, b_in} = ~p;
      end else if (r == 1) begin
        if ($urandom_range(0, 1) == 1) a_in = ~a_in;
        else b_in = ~b_in;
        repeat ($urandom_range(1, FL - 1)) begin
          @(negedge clk);
          ncmp++;
          if ({step, up, err, err_sticky} !==
              {m_step, m_up, m_err, m_stk}) begin
            nbad++;
            $display("FAIL rand_gl cyc=%0d got=%b exp=%b", m_cyc,
                     {step, up, err, err_sticky},
                     {m_step, m_up, m_err, m_stk});
          end
        end
        {a_in, b_in} = p;
      end else if (r == 2) begin
        err_clr = 1'b1;
        n = 1;
      end else if ($urandom_range(0, 1) == 1) begin
        if (p[0] == p[1]) a_in = ~a_in;
        else b_in = ~b_in;
      end else begin
        if (p[0] == p[1]) b_in = ~b_in;
        else a_in = ~a_in;
      end
      repeat (n) begin
        @(negedge clk);
        err_clr = 1'b0;
        ncmp++;
        if ({step, up, err, err_sticky} !==
            {m_step, m_up, m_err, m_stk}) begin
          nbad++;
          $display("FAIL random cyc=%0d got=%b exp=%b", m_cyc,
                   {step, up, err, err_sticky},
                   {m_step, m_up, m_err, m_stk});
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    a_in    = 1'b0;
    b_in    = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_up_seq();
    test_down_rev();
    test_glitch();
    test_err();
    test_reseed();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
